// File: rtl/basic_gates_pkg.sv
// basic_gates_pkg: shared constants and types for the basic-gates lab block.
//   DEF_WIDTH  - default operand width (one switch bit per operand)
//   DEF_CNT_W  - default width of the input-change counter
//   gate_sel_e - gate selector shared by LED mappers and benches
package basic_gates_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [2:0] {
    G_AND  = 3'd0,
    G_OR   = 3'd1,
    G_XOR  = 3'd2,
    G_NAND = 3'd3,
    G_NOR  = 3'd4,
    G_XNOR = 3'd5
  } gate_sel_e;

endpackage

// File: rtl/basic_gates_if.sv
// basic_gates_if: switch operands in, registered gate results out.
//   SW0, SW1        - operands A and B (WIDTH bits each)
//   y_and .. y_xnor - registered bitwise gate results (WIDTH bits each)
//   y_valid         - outputs reflect a sampled input
//   chg_cnt         - saturating count of edges where the inputs changed
// The master modport drives the switches; the slave modport is the gate block.
interface basic_gates_if
  import basic_gates_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic [WIDTH-1:0] SW0;
  logic [WIDTH-1:0] SW1;
  logic [WIDTH-1:0] y_and;
  logic [WIDTH-1:0] y_or;
  logic [WIDTH-1:0] y_xor;
  logic [WIDTH-1:0] y_nand;
  logic [WIDTH-1:0] y_nor;
  logic [WIDTH-1:0] y_xnor;
  logic             y_valid;
  logic [CNT_W-1:0] chg_cnt;

  modport master (
    output SW0, SW1,
    input  y_and, y_or, y_xor, y_nand, y_nor, y_xnor, y_valid, chg_cnt
  );

  modport slave (
    input  SW0, SW1,
    output y_and, y_or, y_xor, y_nand, y_nor, y_xnor, y_valid, chg_cnt
  );

endinterface

// File: rtl/basic_gates_sync2.sv
// basic_gates_sync2: two-flop synchronizer for asynchronous switch inputs.
//   clk - system clock
//   rst - synchronous active-high reset, clears both flops
//   d   - asynchronous input (WIDTH bits)
//   q   - input retimed to clk, two cycles late
module basic_gates_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/basic_gates.sv
// basic_gates: registered AND/OR/XOR and complements of two switch operands,
// with an output-valid flag and a saturating input-change counter.
//   clk - system clock, rising edge
//   rst - synchronous active-high reset; clears outputs, counter and history
//   bus - basic_gates_if.slave: SW0/SW1 in, y_* / y_valid / chg_cnt out
// Build option: BASIC_GATES_SYNC_IN_EN inserts a two-flop synchronizer on
// each operand (latency 3 cycles instead of 1). Leave it undefined only when
// SW0/SW1 are already synchronous to clk.
module basic_gates
  import basic_gates_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  basic_gates_if.slave bus
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0]   a_p0;
  logic [WIDTH-1:0]   b_p0;
  logic               vld_p0;
  logic [2*WIDTH-1:0] cur_p0;

  logic [WIDTH-1:0]   and_p1;
  logic [WIDTH-1:0]   or_p1;
  logic [WIDTH-1:0]   xor_p1;
  logic [WIDTH-1:0]   nand_p1;
  logic [WIDTH-1:0]   nor_p1;
  logic [WIDTH-1:0]   xnor_p1;
  logic               vld_p1;
  logic [2*WIDTH-1:0] prev_p1;
  logic [CNT_W-1:0]   cnt_p1;

  // ---- stage p0: operand capture (optionally synchronized) ----
`ifdef BASIC_GATES_SYNC_IN_EN
  logic [1:0] vld_sync;

  basic_gates_sync2 #(.WIDTH(WIDTH)) u_sync_a (
    .clk (clk),
    .rst (rst),
    .d   (bus.SW0),
    .q   (a_p0)
  );

  basic_gates_sync2 #(.WIDTH(WIDTH)) u_sync_b (
    .clk (clk),
    .rst (rst),
    .d   (bus.SW1),
    .q   (b_p0)
  );

  // Valid walks through the synchronizer depth so y_valid only rises once
  // real switch data (not the reset zeros) reaches the gate stage.
  always_ff @(posedge clk) begin
    if (rst) vld_sync <= '0;
    else     vld_sync <= {vld_sync[0], 1'b1};
  end

  assign vld_p0 = vld_sync[1];
`else
  assign a_p0   = bus.SW0;
  assign b_p0   = bus.SW1;
  assign vld_p0 = 1'b1;
`endif

  assign cur_p0 = {a_p0, b_p0};

  // ---- stage p1: gate results, change history, counter ----
  // Complements are forced to 0 in reset as well so every LED is dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      and_p1  <= '0;
      or_p1   <= '0;
      xor_p1  <= '0;
      nand_p1 <= '0;
      nor_p1  <= '0;
      xnor_p1 <= '0;
      vld_p1  <= 1'b0;
      prev_p1 <= '0;
      cnt_p1  <= '0;
    end else begin
      and_p1  <= a_p0 & b_p0;
      or_p1   <= a_p0 | b_p0;
      xor_p1  <= a_p0 ^ b_p0;
      nand_p1 <= ~(a_p0 & b_p0);
      nor_p1  <= ~(a_p0 | b_p0);
      xnor_p1 <= ~(a_p0 ^ b_p0);
      vld_p1  <= vld_p0;
      prev_p1 <= cur_p0;
      // One count per edge with any differing bit, not per changed bit.
      if (cur_p0 != prev_p1) cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign bus.y_and   = and_p1;
  assign bus.y_or    = or_p1;
  assign bus.y_xor   = xor_p1;
  assign bus.y_nand  = nand_p1;
  assign bus.y_nor   = nor_p1;
  assign bus.y_xnor  = xnor_p1;
  assign bus.y_valid = vld_p1;
  assign bus.chg_cnt = cnt_p1;

endmodule

// File: tb/tb_basic_gates.sv
// tb_basic_gates: directed bench for basic_gates.
//   bi - WIDTH=1, CNT_W=8 instance: reset, truth table, change count, mid-run reset
//   bs - WIDTH=1, CNT_W=2 instance: counter saturation
//   bw - WIDTH=4, CNT_W=8 instance: bitwise independence, one count per edge
module tb_basic_gates;

`ifdef BASIC_GATES_SYNC_IN_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  basic_gates_if #(.WIDTH(1), .CNT_W(8)) bi ();
  basic_gates_if #(.WIDTH(1), .CNT_W(2)) bs ();
  basic_gates_if #(.WIDTH(4), .CNT_W(8)) bw ();

  basic_gates #(.WIDTH(1), .CNT_W(8)) u_dut (.clk(clk), .rst(rst), .bus(bi));
  basic_gates #(.WIDTH(1), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(bs));
  basic_gates #(.WIDTH(4), .CNT_W(8)) u_wid (.clk(clk), .rst(rst), .bus(bw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bi(input string tag,
                        input logic e_and, input logic e_or, input logic e_xor,
                        input logic e_nand, input logic e_nor, input logic e_xnor,
                        input logic e_vld, input logic [7:0] e_cnt);
    chk({tag, "_and"},  32'(bi.y_and),   32'(e_and));
    chk({tag, "_or"},   32'(bi.y_or),    32'(e_or));
    chk({tag, "_xor"},  32'(bi.y_xor),   32'(e_xor));
    chk({tag, "_nand"}, 32'(bi.y_nand),  32'(e_nand));
    chk({tag, "_nor"},  32'(bi.y_nor),   32'(e_nor));
    chk({tag, "_xnor"}, 32'(bi.y_xnor),  32'(e_xnor));
    chk({tag, "_vld"},  32'(bi.y_valid), 32'(e_vld));
    chk({tag, "_cnt"},  32'(bi.chg_cnt), 32'(e_cnt));
  endtask

  // Apply a new operand pair and wait until it is visible on the outputs.
  task automatic apply(input logic a, input logic b);
    bi.SW0 = a;
    bi.SW1 = b;
    repeat (LAT) tick();
  endtask

  initial begin
    int e;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bi.SW0 = 1'b1;
    bi.SW1 = 1'b1;
    bs.SW0 = 1'b0;
    bs.SW1 = 1'b0;
    bw.SW0 = 4'h0;
    bw.SW1 = 4'h0;

    // Reset held 3 cycles with both switches high: everything dark.
    repeat (3) tick();
    chk_bi("rst", 0, 0, 0, 0, 0, 0, 0, 8'd0);
    chk("rst_sat_cnt", 32'(bs.chg_cnt), 32'd0);

    // Release with 00; valid rises after LAT non-reset edges.
    rst    = 1'b0;
    bi.SW0 = 1'b0;
    bi.SW1 = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      chk("valid_rise", 32'(bi.y_valid), (i == LAT) ? 32'd1 : 32'd0);
    end
    chk_bi("tt00", 0, 0, 0, 1, 1, 1, 1, 8'd0);
    repeat (5 - LAT) tick();
    chk_bi("tt00_hold", 0, 0, 0, 1, 1, 1, 1, 8'd0);

    apply(1'b0, 1'b1);
    chk_bi("tt01", 0, 1, 1, 1, 0, 0, 1, 8'd1);
    repeat (5 - LAT) tick();
    chk_bi("tt01_hold", 0, 1, 1, 1, 0, 0, 1, 8'd1);

    apply(1'b1, 1'b0);
    chk_bi("tt10", 0, 1, 1, 1, 0, 0, 1, 8'd2);
    repeat (5 - LAT) tick();
    chk_bi("tt10_hold", 0, 1, 1, 1, 0, 0, 1, 8'd2);

    apply(1'b1, 1'b1);
    chk_bi("tt11", 1, 1, 0, 0, 0, 1, 1, 8'd3);

    // Inputs held: no further counting.
    repeat (20) tick();
    chk_bi("hold11", 1, 1, 0, 0, 0, 1, 1, 8'd3);

    // Mid-run reset pulse at 11 with count 3.
    rst = 1'b1;
    tick();
    chk_bi("midrst", 0, 0, 0, 0, 0, 0, 0, 8'd0);
    rst = 1'b0;
    repeat (LAT) tick();
    chk_bi("after_rst", 1, 1, 0, 0, 0, 1, 1, 8'd1);

    // Saturation on the 2-bit counter: toggle SW0 every edge for 10 edges.
    for (int i = 1; i <= 10; i++) begin
      bs.SW0 = ~bs.SW0;
      tick();
      e = i - (LAT - 1);
      if (e < 0) e = 0;
      if (e > 3) e = 3;
      chk("sat_cnt", 32'(bs.chg_cnt), 32'(e));
    end

    // Multi-bit operands: bitwise gates, one count per changing edge.
    bw.SW0 = 4'b1010;
    bw.SW1 = 4'b0110;
    repeat (LAT) tick();
    chk("w1_and",  32'(bw.y_and),  32'h2);
    chk("w1_or",   32'(bw.y_or),   32'he);
    chk("w1_xor",  32'(bw.y_xor),  32'hc);
    chk("w1_nand", 32'(bw.y_nand), 32'hd);
    chk("w1_nor",  32'(bw.y_nor),  32'h1);
    chk("w1_xnor", 32'(bw.y_xnor), 32'h3);
    chk("w1_cnt",  32'(bw.chg_cnt), 32'd1);

    bw.SW0 = 4'b0101;
    bw.SW1 = 4'b1001;
    repeat (LAT) tick();
    chk("w2_and",  32'(bw.y_and),  32'h1);
    chk("w2_or",   32'(bw.y_or),   32'hd);
    chk("w2_xor",  32'(bw.y_xor),  32'hc);
    chk("w2_nand", 32'(bw.y_nand), 32'he);
    chk("w2_nor",  32'(bw.y_nor),  32'h2);
    chk("w2_xnor", 32'(bw.y_xnor), 32'h3);
    chk("w2_cnt",  32'(bw.chg_cnt), 32'd2);

`ifdef BASIC_GATES_SYNC_IN_EN
    // Synchronizer depth: a 00->11 change sampled at edge N shows at N+2.
    rst    = 1'b1;
    bi.SW0 = 1'b0;
    bi.SW1 = 1'b0;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    bi.SW0 = 1'b1;
    bi.SW1 = 1'b1;
    tick();
    chk("sync_n0", 32'(bi.y_and), 32'd0);
    tick();
    chk("sync_n1", 32'(bi.y_and), 32'd0);
    tick();
    chk("sync_n2", 32'(bi.y_and), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/basic_gates.md
Name: basic_gates

Overview:
- Registered two-operand logic-gate block driven by board switches SW0/SW1.
- Produces AND, OR and XOR plus their complements (NAND, NOR, XNOR), all registered on `clk`.
- Adds an input-change counter and an output-valid flag.
- Sits directly behind the switch inputs and feeds LEDs or downstream logic in the basic-gates lab design.

Parameters:
- WIDTH, 1, bit width of each switch operand; all gates are applied bitwise.
- CNT_W, 8, width of the input-change counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- SW0  input  WIDTH  operand A (switch 0).
- SW1  input  WIDTH  operand B (switch 1).
- y_and  output  WIDTH  registered SW0 & SW1.
- y_or  output  WIDTH  registered SW0 | SW1.
- y_xor  output  WIDTH  registered SW0 ^ SW1.
- y_nand  output  WIDTH  registered ~(SW0 & SW1).
- y_nor  output  WIDTH  registered ~(SW0 | SW1).
- y_xnor  output  WIDTH  registered ~(SW0 ^ SW1).
- y_valid  output  1  outputs reflect a sampled input.
- chg_cnt  output  CNT_W  count of clock edges at which {SW0,SW1} differed from the previous sample.

Behaviour:
- All state updates on the rising edge of clk only; no combinational path from SW0/SW1 to any output.
- Reset (rst=1 at a clock edge):
  - y_and, y_or, y_xor, y_nand, y_nor, y_xnor, y_valid and chg_cnt all go to 0.
  - The previous-sample register is cleared to 0.
  - Complement outputs are 0 in reset (not 1); this is intentional so all LEDs are dark during reset.
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N; every gate output updates on every non-reset edge.
- y_valid: 0 during reset; 1 from the first non-reset edge onward; stays 1 until the next reset.
- Change detection:
  - A previous-sample register holds {SW0,SW1} from the last non-reset edge.
  - The first non-reset edge after reset compares against the cleared value 0.
  - If the current and previous samples differ, chg_cnt increments by 1.
  - chg_cnt saturates at 2^CNT_W-1 and does not wrap.
- Reset mid-operation: takes priority over everything that edge; counter and outputs clear immediately.
- Inputs held constant: outputs stable, chg_cnt unchanged.
- WIDTH>1: each bit is independent. chg_cnt counts edges where any bit changed, not the number of changed bits.

Optional Feature:
- Macro BASIC_GATES_SYNC_IN_EN.
- When defined:
  - SW0/SW1 pass through a two-flop synchronizer (reset to 0) before the gate and change logic.
  - Total latency becomes 3 cycles.
  - y_valid rises on the third non-reset edge.
- When undefined: no synchronizer, 1-cycle latency as above. Use the undefined build only when inputs are already synchronous to clk.

Decomposition:
- Package basic_gates_pkg holds:
  - Default WIDTH/CNT_W constants.
  - A gate-select enum (G_AND, G_OR, G_XOR, G_NAND, G_NOR, G_XNOR) for shared use by testbenches and LED mappers.
- One natural sub-module, sync2, the two-flop synchronizer. It is instantiated per operand only under BASIC_GATES_SYNC_IN_EN.

Test Plan:
- Reset check: assert rst for 3 cycles with SW0=1, SW1=1 -> every output 0, y_valid=0, chg_cnt=0.
- Truth-table walk: release reset, step {SW0,SW1} through 00,01,10,11 holding each 5 cycles; one cycle after each step:
  - 00 -> and=0, or=0, xor=0, nand=1, nor=1, xnor=1.
  - 01 and 10 -> and=0, or=1, xor=1, nand=1, nor=0, xnor=0.
  - 11 -> and=1, or=1, xor=0, nand=0, nor=0, xnor=1.
  - y_valid=1 throughout.
- Change counting: after the walk above, chg_cnt=3 (00 matches the cleared sample). Hold 11 for 20 cycles -> chg_cnt remains 3.
- Saturation: with CNT_W=2, toggle SW0 every cycle for 10 cycles -> chg_cnt reaches 3 and stays 3.
- Mid-run reset: at {SW0,SW1}=11 with chg_cnt=3, pulse rst for 1 cycle -> all outputs 0 on that edge. The next edge gives and=1, xnor=1, chg_cnt=1.
- Sync option (BASIC_GATES_SYNC_IN_EN defined): change 00->11 at edge N -> y_and=1 after edge N+2, not before; y_valid first 1 after the third non-reset edge.
